// File: rtl/dm_pkg.sv
// Shared definitions for the handshaked data memory: access-type codes and FSM encoding.
package dm_pkg;

  // dm_type codes; any other value is an illegal access
  localparam logic [2:0] DMT_W  = 3'b000;
  localparam logic [2:0] DMT_H  = 3'b100;
  localparam logic [2:0] DMT_HU = 3'b101;
  localparam logic [2:0] DMT_B  = 3'b110;
  localparam logic [2:0] DMT_BU = 3'b111;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_hs_if.sv
// Request/response bundle between a requester (master) and the data memory (slave).
interface dmem_hs_if;

  logic        req;
  logic        we;
  logic [2:0]  dm_type;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        ready;
  logic        ack;
  logic [31:0] rd;
  logic        fault;

  modport master (
    output req, we, dm_type, addr, wd,
    input  ready, ack, rd, fault
  );

  modport slave (
    input  req, we, dm_type, addr, wd,
    output ready, ack, rd, fault
  );

endinterface

// File: rtl/dm_lane.sv
// Combinational lane logic: store merge, load extract/extend and access legality check.
module dm_lane
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [31:0] word_in,
  output logic [31:0] word_out,
  output logic [31:0] rd_val,
  output logic        fault
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  assign half   = addr[1] ? word_in[31:16] : word_in[15:0];
  assign byte_v = word_in[{addr[1:0], 3'b000} +: 8];

  // Decode access type into merged store word, extended load value and fault
  always_comb begin
    word_out = word_in;
    rd_val   = '0;
    fault    = 1'b0;
    case (dm_type)
      DMT_W: begin
        fault    = (addr[1:0] != 2'b00);
        word_out = wd;
        rd_val   = word_in;
      end
      DMT_H, DMT_HU: begin
        fault = addr[0];
        if (addr[1]) word_out[31:16] = wd[15:0];
        else         word_out[15:0]  = wd[15:0];
        rd_val = (dm_type == DMT_H) ? {{16{half[15]}}, half} : {16'h0000, half};
      end
      DMT_B, DMT_BU: begin
        word_out[{addr[1:0], 3'b000} +: 8] = wd[7:0];
        rd_val = (dm_type == DMT_B) ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
      end
      default: fault = 1'b1;
    endcase
    // Anything above the implemented word range is rejected rather than aliased
    if ((addr >> (ADDR_W + 2)) != 32'd0) fault = 1'b1;
    if (fault) rd_val = '0;
  end

endmodule

// File: rtl/dmem_hs.sv
// Word-organised data memory with a fixed-latency req/ready/ack handshake and
// a post-reset clearing sweep.
module dmem_hs
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned WAIT   = 4
) (
  input  logic      clk,
  input  logic      reset,
  dmem_hs_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        wait_cnt;
  logic              we_q;
  logic [2:0]        dmt_q;
  logic [31:0]       addr_q, wd_q, rd_q;
  logic              fault_q;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       word_rd, merged, ld_val;
  logic              lane_fault;
  logic              access;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [31:0]       mem_wdata;

  assign word_idx = addr_q[ADDR_W+1:2];
  assign word_rd  = mem[word_idx];
  assign access   = (state == BUSY) && (wait_cnt == 8'd0);

  dm_lane #(
    .ADDR_W (ADDR_W)
  ) u_lane (
    .dm_type  (dmt_q),
    .addr     (addr_q),
    .wd       (wd_q),
    .word_in  (word_rd),
    .word_out (merged),
    .rd_val   (ld_val),
    .fault    (lane_fault)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      CLEAR: if (clr_cnt == ADDR_W'(DEPTH - 1)) state_next = IDLE;
      IDLE:  if (bus.req) state_next = BUSY;
      BUSY:  if (wait_cnt == 8'd0) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  // Sweep counter, request latch, wait counter and captured response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt  <= '0;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      dmt_q    <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      rd_q     <= '0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: clr_cnt <= clr_cnt + 1'b1;
        IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            dmt_q    <= bus.dm_type;
            addr_q   <= bus.addr;
            wd_q     <= bus.wd;
            wait_cnt <= 8'(WAIT - 1);
          end
        end
        BUSY: begin
          if (wait_cnt != 8'd0) begin
            wait_cnt <= wait_cnt - 8'd1;
          end else begin
            fault_q <= lane_fault;
            rd_q    <= (lane_fault || we_q) ? 32'd0 : ld_val;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory write port: clearing sweep has priority, then legal stores
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_wdata = merged;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_cnt;
      mem_wdata = '0;
    end else if (access && we_q && !lane_fault) begin
      mem_we = 1'b1;
    end
  end

  // Storage array, no reset: contents are zeroed by the sweep
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  assign bus.ready = (state == IDLE);
  assign bus.ack   = (state == RESP);
  assign bus.rd    = (state == RESP) ? rd_q : 32'd0;
  assign bus.fault = (state == RESP) ? fault_q : 1'b0;

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: directed scenarios plus random accesses
// compared against a byte-array reference model.
module tb_dmem_hs;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WAIT   = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned NBYTES = 4 * DEPTH;

  logic clk = 1'b0;
  logic reset;

  dmem_hs_if bus ();

  dmem_hs #(
    .ADDR_W (ADDR_W),
    .WAIT   (WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mbytes [NBYTES];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
  endtask

  // Reference: memory as a flat little-endian byte array
  task automatic model_access(input logic w, input logic [2:0] t, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] r, output logic f);
    int sz;
    bit sgn;
    sz  = 0;
    sgn = 0;
    case (t)
      3'b000: sz = 4;
      3'b100: begin sz = 2; sgn = 1; end
      3'b101: sz = 2;
      3'b110: begin sz = 1; sgn = 1; end
      3'b111: sz = 1;
      default: sz = 0;
    endcase
    f = (sz == 0) || (a >= NBYTES);
    if (sz != 0 && (a % sz) != 0) f = 1'b1;
    r = 32'd0;
    if (!f) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mbytes[int'(a) + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) r[8*i +: 8] = mbytes[int'(a) + i];
        if (sgn && r[8*sz-1]) r = r | ~((32'd1 << (8 * sz)) - 32'd1);
      end
    end
  endtask

  // Wait for ready at negedges; returns number of cycles waited
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!bus.ready && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
    if (!bus.ready) check_val("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  // One complete access, checked against the model
  task automatic do_access(input logic w, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] d, input string tag);
    logic [31:0] exp_rd;
    logic        exp_f;
    int          lat;
    int          dummy;
    wait_ready(dummy);
    model_access(w, t, a, d, exp_rd, exp_f);
    bus.req     = 1'b1;
    bus.we      = w;
    bus.dm_type = t;
    bus.addr    = a;
    bus.wd      = d;
    @(negedge clk);
    bus.req = 1'b0;
    lat = 1;
    while (!bus.ack && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(WAIT + 1));
    check_val({tag, "_fault"}, 32'(bus.fault), 32'(exp_f));
    if (!w) check_val({tag, "_rd"}, bus.rd, exp_rd);
    @(negedge clk);
    check_val({tag, "_ack_low"}, {bus.ack, bus.fault, 30'd0}, 32'd0);
    check_val({tag, "_rd_low"}, bus.rd, 32'd0);
  endtask

  int          cyc;
  int          accepts [$];
  int          n_ack;
  bit          saw_ack;
  logic [31:0] r;
  logic        f;
  logic [2:0]  rt;
  logic [31:0] ra;

  initial begin
    reset       = 1'b1;
    bus.req     = 1'b0;
    bus.we      = 1'b0;
    bus.dm_type = 3'b000;
    bus.addr    = 32'd0;
    bus.wd      = 32'd0;
    model_clear();
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {bus.ready, bus.ack, bus.fault, 29'd0}, 32'd0);
    check_val("reset_rd", bus.rd, 32'd0);

    // Reset release: sweep takes DEPTH cycles
    reset = 1'b0;
    cyc   = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.ready && cyc < 1000);
    check_val("clear_cycles", 32'(cyc), 32'(DEPTH));
    do_access(1'b0, 3'b000, 32'h7C, 32'd0, "ld_w_7c");

    do_access(1'b1, 3'b000, 32'h08, 32'h11223344, "st_w_08");
    do_access(1'b0, 3'b110, 32'h0B, 32'd0, "ld_b_0b");
    do_access(1'b1, 3'b110, 32'h09, 32'h00000080, "st_b_09");
    do_access(1'b0, 3'b000, 32'h08, 32'd0, "ld_w_08");
    do_access(1'b0, 3'b110, 32'h09, 32'd0, "ld_b_09");
    do_access(1'b0, 3'b111, 32'h09, 32'd0, "ld_bu_09");
    do_access(1'b0, 3'b100, 32'h0A, 32'd0, "ld_h_0a");
    do_access(1'b0, 3'b100, 32'h03, 32'd0, "ld_h_03");
    do_access(1'b1, 3'b000, 32'h00, 32'hCAFEF00D, "st_w_00");
    do_access(1'b1, 3'b000, 32'h80, 32'h12345678, "st_w_80");
    do_access(1'b0, 3'b000, 32'h00, 32'd0, "ld_w_00");
    do_access(1'b0, 3'b010, 32'h00, 32'd0, "ld_bad_type");

    // Reset during BUSY of a store: pending access dropped, memory re-zeroed
    do_access(1'b1, 3'b000, 32'h10, 32'h55AA55AA, "st_w_10_pre");
    bus.req     = 1'b1;
    bus.we      = 1'b1;
    bus.dm_type = 3'b000;
    bus.addr    = 32'h10;
    bus.wd      = 32'hDEADBEEF;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midbusy_reset_out", {bus.ready, bus.ack, bus.fault, 29'd0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    saw_ack = 1'b0;
    cyc     = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.ack) saw_ack = 1'b1;
    end while (!bus.ready && cyc < 1000);
    check_val("midbusy_no_ack", 32'(saw_ack), 32'd0);
    check_val("reclear_cycles", 32'(cyc), 32'(DEPTH));
    do_access(1'b0, 3'b000, 32'h10, 32'd0, "ld_w_10_after");

    // req held high: accepts only when ready, spaced WAIT+2 apart
    do_access(1'b1, 3'b000, 32'h04, 32'h0BADF00D, "st_w_04");
    wait_ready(cyc);
    bus.req     = 1'b1;
    bus.we      = 1'b0;
    bus.dm_type = 3'b000;
    bus.addr    = 32'h04;
    n_ack       = 0;
    model_access(1'b0, 3'b000, 32'h04, 32'd0, r, f);
    for (int c = 0; c < 3 * (WAIT + 2); c++) begin
      if (bus.ready) accepts.push_back(c);
      if (bus.ack) begin
        n_ack++;
        check_val("held_rd", bus.rd, r);
      end
      @(negedge clk);
    end
    bus.req = 1'b0;
    check_val("held_accepts", 32'(accepts.size()), 32'd3);
    check_val("held_acks", 32'(n_ack), 32'd3);
    for (int i = 1; i < accepts.size(); i++)
      check_val("held_spacing", 32'(accepts[i] - accepts[i-1]), 32'(WAIT + 2));
    repeat (WAIT + 3) @(negedge clk);

    // Random traffic, mostly in range and mostly legal types
    for (int n = 0; n < 200; n++) begin
      rt = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) rt = {1'b1, 2'($urandom_range(0, 3))};
      ra = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 15) == 0) ra = $urandom;
      do_access(1'($urandom_range(0, 1)), rt, ra, $urandom, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
